sysu_ser_tx: RTL and testbench

//  - Serial frame transmitter: accepts a parallel word, shifts it out on a single line as

---
 rtl/sysu_ser_tx.sv | 165 ++++++++++++++++
 tb/tb_sysu_ser_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysu_ser_tx.sv
// sysu_ser_tx: serial frame transmitter for the sysu serial link.
// Frame = start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
// Line idles high. Each bit is held for CLK_DIV clocks.
// Optional feature macro: SYSU_SER_TX_PARITY_EN. When defined, a PARITY state sends one
// even-parity bit between the last data bit and the stop bit. Port list is the same in both builds.
`timescale 1ns/1ps

module sysu_ser_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 16,
    parameter int DELAY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              txd,
    output logic              done
);

    // A single-bit counter is still needed when DATA_W or CLK_DIV would give a zero width.
    localparam int BW  = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SYSU_SER_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [DVW-1:0]    div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic              txd_r;
    logic              ready_r;
    logic              done_r;
    logic              bit_end;
`ifdef SYSU_SER_TX_PARITY_EN
    logic              par_r;
`endif

    // Next shift-register value; using its bit 0 avoids indexing shreg[1] when DATA_W is 1.
    assign sh_next = shreg >> 1;

    // A bit period ends on the edge where the divider reaches its last count.
    assign bit_end = (div_cnt == DIV_LAST);

    // Frame sequencer: every output is registered so txd never glitches at state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            txd_r   <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
`ifdef SYSU_SER_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    txd_r   <= 1'b1;
                    ready_r <= 1'b1;
                    if (load) begin
                        // Accept: word is frozen here, later din changes are ignored.
                        shreg   <= din;
`ifdef SYSU_SER_TX_PARITY_EN
                        par_r   <= ^din;
`endif
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_START;
                        txd_r   <= 1'b0;
                        ready_r <= 1'b0;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                        txd_r   <= shreg[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef SYSU_SER_TX_PARITY_EN
                            state <= S_PARITY;
                            txd_r <= par_r;
`else
                            state <= S_STOP;
                            txd_r <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= sh_next;
                            txd_r   <= sh_next[0];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

`ifdef SYSU_SER_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= S_STOP;
                        txd_r   <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        // Frame complete: back to idle with a one-cycle done pulse.
                        div_cnt <= '0;
                        state   <= S_IDLE;
                        txd_r   <= 1'b1;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a quiet idle line.
                    state   <= S_IDLE;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    txd_r   <= 1'b1;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Registered outputs reach the pins after the modelled propagation delay.
    assign #DELAY txd   = txd_r;
    assign #DELAY ready = ready_r;
    assign #DELAY done  = done_r;

endmodule

// File: tb/tb_sysu_ser_tx.sv
// Bench for sysu_ser_tx: frame-level reference model plus directed and random stimulus.
// Build with or without SYSU_SER_TX_PARITY_EN; expectations follow the macro.
`timescale 1ns/1ps

module tb_sysu_ser_tx;
    localparam int DW = 8;
    localparam int CD = 4;
    localparam int DL = 3;
`ifdef SYSU_SER_TX_PARITY_EN
    localparam int NB = DW + 3;
    localparam logic [31:0] EXP_A5 = 32'b10101001010;
    localparam logic [31:0] EXP_07 = 32'b11000001110;
`else
    localparam int NB = DW + 2;
    localparam logic [31:0] EXP_A5 = 32'b1101001010;
    localparam logic [31:0] EXP_07 = 32'b1000001110;
`endif
    localparam int FLEN = NB * CD;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] din  = '0;
    wire           txd, ready, done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sysu_ser_tx #(.DATA_W(DW), .CLK_DIV(CD), .DELAY(DL)) dut (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .ready(ready), .txd(txd), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position inside the current frame (-1 = idle) and the frame's bit list.
    int m_pos  = -1;
    bit m_done = 1'b0;
    bit fb[NB];

    function automatic void m_latch(input logic [DW-1:0] d);
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[i+1] = d[i];
`ifdef SYSU_SER_TX_PARITY_EN
        fb[DW+1] = ^d;
`endif
        fb[NB-1] = 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else if (m_pos >= 0) begin
            m_pos++;
            m_done = 1'b0;
            if (m_pos == FLEN) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_latch(din);
                m_pos = 0;
            end
        end
    end

    // Per-cycle comparison against the model, well after the output delay.
    always @(negedge clk) begin
        if (chk_en) begin
            check("txd",   {31'd0, txd},   (m_pos < 0) ? 32'd1 : {31'd0, fb[m_pos / CD]});
            check("ready", {31'd0, ready}, (m_pos < 0) ? 32'd1 : 32'd0);
            check("done",  {31'd0, done},  {31'd0, m_done});
        end
    end

    // Send one word and capture the mid-bit samples, the busy length and the done flag.
    task automatic send_capture(input logic [DW-1:0] d, output logic [31:0] bits,
                                output int len, output logic dn);
        din  = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        len  = 0;
        bits = '0;
        while (!ready && len < 200) begin
            if (len % CD == 1) bits[len / CD] = txd;
            len++;
            @(negedge clk);
        end
        dn = done;
    endtask

    initial begin
        logic [31:0] bits;
        int          len;
        logic        dn;
        int          k;
        int          t;
        int          nd;
        int          last;

        // Reset, then 20 idle clocks.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_txd",   {31'd0, txd},   32'd1);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_done",  {31'd0, done},  32'd0);

        // Single A5 frame.
        send_capture(8'hA5, bits, len, dn);
        check("a5_bits", bits, EXP_A5);
        check("a5_len",  len,  FLEN);
        check("a5_done", {31'd0, dn}, 32'd1);
        repeat (3) @(negedge clk);

        // Frame 07 exercises a set parity bit.
        send_capture(8'h07, bits, len, dn);
        check("x07_bits", bits, EXP_07);
        check("x07_len",  len,  FLEN);
        repeat (2) @(negedge clk);

        // Load held during a frame with a different word: first frame unaltered.
        din  = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        din = 8'h3C;
        k = 0;
        while (!done && k < 200) begin
            k++;
            @(negedge clk);
        end
        check("busy_len",       k, FLEN);
        check("busy_idle_txd",  {31'd0, txd},   32'd1);
        check("busy_idle_rdy",  {31'd0, ready}, 32'd1);
        @(negedge clk);
        check("busy_acc_rdy", {31'd0, ready}, 32'd0);
        check("busy_acc_txd", {31'd0, txd},   32'd0);
        load = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            k++;
            @(negedge clk);
        end
        check("x3c_len", k, FLEN);
        repeat (2) @(negedge clk);

        // Reset 17 clocks into an FF frame.
        din  = 8'hFF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (17) @(negedge clk);
        #1 rst = 1'b1;
        #3.5;
        check("rst_txd",   {31'd0, txd},   32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        k = 0;
        while (k < 5) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
            k++;
        end
        send_capture(8'h00, bits, len, dn);
        check("x00_bits", bits, 32'd1 << (NB - 1));
        check("x00_len",  len,  FLEN);
        repeat (2) @(negedge clk);

        // Continuous load for three frames: done pulses FLEN+1 apart.
        din  = 8'h01;
        load = 1'b1;
        t = 0; nd = 0; last = 0;
        while (nd < 3 && t < 500) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (nd > 0) check("b2b_gap", t - last, FLEN + 1);
                last = t;
                nd++;
                if (nd == 1) din = 8'h80;
                else if (nd == 2) din = 8'h55;
                else load = 1'b0;
            end
        end
        check("b2b_count", nd, 3);
        load = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic, with rare asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            din  = DW'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        load = 1'b0;
        repeat (FLEN + 4) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
